// File: rtl/spi_word_rx_pkg.sv
// Shared definitions for the SPI word receiver: state encoding and default sizes.
package spi_rx_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RECV = 1'b1;

  localparam int DEFAULT_WORD_BITS   = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE = ST_IDLE,
    RECV = ST_RECV
  } rx_state_e;

endpackage

// File: rtl/spi_word_rx_if.sv
// Bus between the SPI pins / downstream decoder and the word receiver.
// slave: the receiver (samples the pins, drives the word outputs).
// master: whoever drives the pins and consumes the words.
interface spi_word_rx_if
  import spi_rx_pkg::*;
#(
  parameter int WORD_BITS = DEFAULT_WORD_BITS
);
  logic                 spi_sck;
  logic                 spi_mosi;
  logic                 spi_cs_n;
  logic                 start;
  logic [WORD_BITS-1:0] word;
  logic                 word_en;
  logic                 busy;
  logic                 timeout;

  modport slave (
    input  spi_sck, spi_mosi, spi_cs_n,
    output start, word, word_en, busy, timeout
  );

  modport master (
    output spi_sck, spi_mosi, spi_cs_n,
    input  start, word, word_en, busy, timeout
  );
endinterface

// File: rtl/spi_word_rx_sync_edge.sv
// Synchroniser for one asynchronous pin plus a history flop for edge detection.
// level, rise and fall are all aligned: rise means level has just become 1.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain_p0;
  logic              hist_p1;
  logic              rise_p1;
  logic              fall_p1;

  // Metastability chain, then history flop with registered edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_p0 <= {STAGES{RESET_VAL}};
      hist_p1  <= RESET_VAL;
      rise_p1  <= 1'b0;
      fall_p1  <= 1'b0;
    end else begin
      chain_p0 <= {chain_p0[STAGES-2:0], din};
      hist_p1  <= chain_p0[STAGES-1];
      rise_p1  <= chain_p0[STAGES-1] & ~hist_p1;
      fall_p1  <= ~chain_p0[STAGES-1] & hist_p1;
    end
  end

  assign level = hist_p1;
  assign rise  = rise_p1;
  assign fall  = fall_p1;

endmodule

// File: rtl/spi_word_rx.sv
// SPI mode-0 slave receiver: oversamples SCK/MOSI/CS_n in the clk domain and
// deserialises MOSI (MSB first) into WORD_BITS-wide words.
// Optional feature macro: SPI_RX_TIMEOUT_EN (aborts a partial word after
// TIMEOUT_CYCLES clk cycles without an SCK rising edge).
module spi_word_rx
  import spi_rx_pkg::*;
#(
  parameter int WORD_BITS      = DEFAULT_WORD_BITS,
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input logic          clk,
  input logic          rst,
  spi_word_rx_if.slave bus
);
  localparam int CNT_W = (WORD_BITS > 2) ? $clog2(WORD_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

  if (SYNC_STAGES < 2 || WORD_BITS < 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("spi_word_rx: unsupported parameter set");
  end

  logic sck_rise;
  logic sck_lvl_unused;
  logic sck_fall_unused;
  logic cs_lvl;
  logic cs_rise;
  logic cs_fall;
  logic mosi_lvl;
  logic mosi_rise_unused;
  logic mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .din(bus.spi_sck),
    .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall_unused)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(bus.spi_cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(bus.spi_mosi),
    .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  rx_state_e            state_q;
  rx_state_e            state_d;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [WORD_BITS-1:0] shift_q;
  logic [WORD_BITS-1:0] shift_next;
  logic [WORD_BITS-1:0] word_q;
  logic                 start_q;
  logic                 word_en_q;
  logic                 timeout_q;

  logic frame_begin;
  logic frame_end;
  logic bit_edge;
  logic word_done;
  logic to_fire;

  // An SCK edge counts only inside a frame while CS is still low in the same
  // cycle, so a coincident CS rise or a CS fall in IDLE swallows the edge.
  assign frame_begin = (state_q == IDLE) && cs_fall;
  assign frame_end   = (state_q == RECV) && cs_rise;
  assign bit_edge    = (state_q == RECV) && sck_rise && !cs_lvl;
  assign word_done   = bit_edge && (bit_cnt_q == LAST_BIT);
  assign shift_next  = {shift_q[WORD_BITS-2:0], mosi_lvl};

`ifdef SPI_RX_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);

  logic [TMR_W-1:0] idle_tmr_q;

  // Cycles since the last counted SCK edge; saturates so it fires at most once
  // per stall, and only when a partial word is actually pending.
  assign to_fire = (state_q == RECV) && !cs_rise && !bit_edge &&
                   (idle_tmr_q == TMR_MAX) && (bit_cnt_q != '0);

  // Idle timer: held at zero outside a frame, restarted by every counted edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_tmr_q <= '0;
    end else if (state_q == IDLE || bit_edge) begin
      idle_tmr_q <= '0;
    end else if (idle_tmr_q != TMR_MAX) begin
      idle_tmr_q <= idle_tmr_q + 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: CS falling edge opens a frame, CS rising edge closes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = RECV;
      RECV:    if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit counter, shift register, held word and the one-cycle strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      word_q    <= '0;
      start_q   <= 1'b0;
      word_en_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      start_q   <= frame_begin;
      word_en_q <= word_done;
      timeout_q <= to_fire;
      if (frame_begin || frame_end || to_fire) begin
        bit_cnt_q <= '0;
        shift_q   <= '0;
      end else if (bit_edge) begin
        bit_cnt_q <= word_done ? '0 : bit_cnt_q + 1'b1;
        shift_q   <= shift_next;
      end
      if (word_done) word_q <= shift_next;
    end
  end

  assign bus.start   = start_q;
  assign bus.word    = word_q;
  assign bus.word_en = word_en_q;
  assign bus.busy    = (state_q == RECV);
  assign bus.timeout = timeout_q;

endmodule

// File: doc/spi_word_rx.md
Name: spi_word_rx

Overview:
- SPI slave front end. Oversamples the external SPI pins in the system clock domain and deserialises MOSI into 16-bit words.
- Drives the command/line decoder directly downstream: start pulse per transaction, word bus, and a one-cycle word_en strobe per complete word.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first, write-only (no MISO).

Parameters:
- WORD_BITS, 16, bits per word; also the width of word.
- SYNC_STAGES, 2, synchroniser flops per SPI input (minimum 2).
- TIMEOUT_CYCLES, 4095, clk cycles with no SCK rising edge before a partial word is aborted (only used with SPI_RX_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; must be at least 4x SCK frequency.
- rst  in  1  asynchronous, active-high reset.
- spi_sck  in  1  SPI clock, asynchronous to clk.
- spi_mosi  in  1  SPI data in, asynchronous.
- spi_cs_n  in  1  SPI chip select, active low, asynchronous.
- start  out  1  one-cycle pulse when a transaction begins.
- word  out  WORD_BITS  last complete word; held until the next one.
- word_en  out  1  one-cycle strobe; word is valid in the same cycle.
- busy  out  1  high while in RECV.
- timeout  out  1  one-cycle pulse on abort (tied 0 without SPI_RX_TIMEOUT_EN).

Behaviour:
- Reset (async, rst=1):
  - Synchroniser chains load idle values: cs_n=1, sck=0, mosi=0.
  - Outputs: start=0, word=0, word_en=0, busy=0, timeout=0.
  - Bit counter=0, shift register=0, state=IDLE.
  - Reset mid-transaction discards the partial word. No word_en is emitted for it.
- Synchronisation:
  - sck, mosi and cs_n each pass through SYNC_STAGES flops plus one history flop for edge detection.
  - mosi uses the same depth as sck, so a sampled bit aligns with its SCK edge.
- State machine (2 states):
  - IDLE: on a synced cs_n falling edge -> RECV; pulse start for one cycle; clear counter and shift register.
  - RECV: on a synced sck rising edge while synced cs_n=0:
    - shift register <= {shift[WORD_BITS-2:0], mosi_sync};
    - counter increments.
  - RECV, counter at WORD_BITS-1 when an edge arrives:
    - word <= the completed value; word_en=1 next cycle; counter wraps to 0.
    - Stay in RECV, so back-to-back words need no CS toggle.
  - RECV, synced cs_n rising edge -> IDLE: partial word discarded, counter cleared, word unchanged.
  - busy = (state==RECV).
- Latency: word_en asserts SYNC_STAGES+2 clk cycles after the pin-level SCK rising edge carrying the last bit (4 with defaults).
- Simultaneous events:
  - SCK rise and CS rise in the same synced cycle: the SCK edge is ignored, because an edge counts only if synced cs_n=0 in that cycle.
  - CS fall and SCK rise in the same synced cycle: start pulses; the SCK edge is ignored (mode 0 requires setup).
- SCK edges while in IDLE are ignored. Glitches are not filtered beyond the synchroniser.
- start and word_en never assert in the same cycle.
- word_en is never asserted in IDLE.

Optional Feature:
- SPI_RX_TIMEOUT_EN defined:
  - An idle counter (clog2(TIMEOUT_CYCLES+1) bits) runs in RECV. It clears on every counted SCK edge and on entry to RECV.
  - When it reaches TIMEOUT_CYCLES with counter != 0: discard the partial word, pulse timeout, clear the bit counter, and stay in RECV. start is not re-asserted.
  - With counter == 0 the timer saturates and never fires.
- SPI_RX_TIMEOUT_EN not defined: no idle counter; timeout tied to 0.

Decomposition:
- Package spi_rx_pkg holds:
  - state encoding localparams ST_IDLE=0, ST_RECV=1;
  - DEFAULT_WORD_BITS=16;
  - DEFAULT_SYNC_STAGES=2.
- Sub-module spi_sync_edge:
  - Parameterised by STAGES and RESET_VAL.
  - Outputs the synced level plus rise and fall pulses.
  - Instantiated three times, for sck, cs_n and mosi (mosi uses the level only).

Test Plan:
- Reset: assert rst mid-word (after 7 bits) -> all outputs 0 immediately. After release, a full transfer of 0x0001 produces word_en with word=0x0001.
- Single word: CS low, shift 0xA5C3 MSB first at clk/8, CS high -> one start pulse; one word_en 4 cycles after the 16th SCK rise; word=0xA5C3 and held after CS rises.
- Back-to-back: 48 bits 0x0001, 0x1234, 0xFFFF in one CS frame -> exactly three word_en pulses with those values; one start.
- Partial abort: CS low, 9 bits, CS high, then a new frame carrying 0x0002 -> no word_en for the partial; word stays at its previous value until 0x0002 arrives; two start pulses.
- Edge ordering: SCK rise coincident with CS rise at pins -> that bit is not counted; busy falls; no word_en.
- Timeout (SPI_RX_TIMEOUT_EN, TIMEOUT_CYCLES=20): 5 bits, then idle for 25 cycles with CS low -> timeout pulses once. The next 16 bits of 0x00FF produce word=0x00FF.
